width_gearbox: RTL



---
 rtl/width_gearbox_pkg.sv | 13 +
 rtl/width_gearbox.sv | 77 +++++++
 2 files changed

// File: rtl/width_gearbox_pkg.sv
// rtl/width_gearbox_pkg.sv - shared types and helpers for the width gearbox
package width_gearbox_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } gb_state_t;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/width_gearbox.sv
// rtl/width_gearbox.sv - MSB-first IN_W to OUT_W stream gearbox with packet flush
module width_gearbox
    import width_gearbox_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 12,
    parameter int BUF_W = IN_W + OUT_W,
    parameter int CNT_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] out_nbits
);

    localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] IN_W_C  = CNT_W'(IN_W);
    // Largest fill level at which a whole input beat still fits without a pop.
    localparam logic [CNT_W-1:0] ROOM_C  = CNT_W'(BUF_W - IN_W);

    gb_state_t          state, state_nxt;
    logic [BUF_W-1:0]   sbuf, sbuf_nxt, sbuf_pop, ins;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_pop, pop_n;
    logic               push, pop;

    // Handshake, output word formation and next buffer/count/state.
    always_comb begin
        pop_n     = CNT_W'(min_u(int'(cnt), OUT_W));
        out_valid = (cnt >= OUT_W_C) || ((state == DRAIN) && (cnt != '0));
        out_nbits = out_valid ? pop_n : '0;
        out_last  = (state == DRAIN) && (cnt <= OUT_W_C) && out_valid;
        // Bits past the fill level are masked so nothing stale or X leaks out.
        out_data  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            out_data[OUT_W-1-i] = sbuf[BUF_W-1-i] & (i < int'(cnt));
        end

        pop      = out_valid & out_ready;
        in_ready = (state == RUN) && ((cnt <= ROOM_C) || pop);
        push     = in_valid & in_ready;

        // Pop first, then append the new beat just below the surviving bits.
        cnt_pop  = pop ? (cnt - pop_n) : cnt;
        sbuf_pop = pop ? (sbuf << pop_n) : sbuf;
        ins      = {in_data, {OUT_W{1'b0}}} >> cnt_pop;
        sbuf_nxt = push ? (sbuf_pop | ins) : sbuf_pop;
        cnt_nxt  = push ? (cnt_pop + IN_W_C) : cnt_pop;

        state_nxt = state;
        case (state)
            RUN:     if (push && in_last && (cnt_nxt != '0)) state_nxt = DRAIN;
            DRAIN:   if (pop && out_last) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Shift buffer, fill count and packet FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbuf  <= '0;
            cnt   <= '0;
            state <= RUN;
        end else begin
            sbuf  <= sbuf_nxt;
            cnt   <= cnt_nxt;
            state <= state_nxt;
        end
    end

endmodule
